pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Front-end PC generator. Produces the fetch address stream that feeds the instruction memory and the IF-stage PC/valid alignment register.
- Advances the PC on accepted fetch requests.
- Redirects on branch resolution and on pipeline flush (exception/ertn).
- Raises an address-fault flag on a misaligned redirect target, then parks until a flush arrives.

Parameters:
ADDR_WIDTH, 32, width of all address ports.
RESET_PC, 32'h1C00_0000, first fetch address after reset.
FETCH_STEP, 4, byte increment per accepted fetch.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  back-pressure from IF stage; when high, no fetch is accepted.
flush  in  1  pipeline flush; redirect to flush_target_i.
flush_target_i  in  ADDR_WIDTH  flush/exception entry address.
branch_flag_i  in  1  branch taken in EX; redirect to branch_target_i.
branch_target_i  in  ADDR_WIDTH  branch target address.
mem_ready_i  in  1  instruction memory accepts a request this cycle.
pc_o  out  ADDR_WIDTH  current fetch address.
req_o  out  1  fetch request valid.
fire_o  out  1  combinational: req_o & mem_ready_i & ~stall.
adef_o  out  1  address-fault flag; valid while in FAULT.
adef_addr_o  out  ADDR_WIDTH  misaligned address that caused the fault.

Behaviour:
- Reset (async, any time, including mid-redirect):
  - pc_o=RESET_PC, req_o=0, adef_o=0, adef_addr_o=0, state=BOOT.
  - Deassertion is sampled on clk.
- States: BOOT, RUN, FAULT. All transitions are on the clk rising edge.
- BOOT:
  - req_o=0 for exactly one cycle after reset release, then go to RUN with pc_o unchanged.
  - A flush or branch in BOOT is handled exactly as in RUN (redirect rules apply, state→RUN or FAULT).
- RUN:
  - req_o=1 except in the cycle a redirect is registered (see below).
  - fire_o=1 → pc_o <= pc_o+FETCH_STEP next cycle.
  - fire_o=0 (stall or !mem_ready_i) → pc_o holds.
- Redirect priority (evaluated every cycle in every state): flush > branch_flag_i > sequential advance.
  - Redirect overrides stall and mem_ready_i. The in-flight fetch is squashed downstream by the same branch/flush signals.
  - On redirect, pc_o <= target next cycle; the old PC is never re-presented.
  - If target[1:0]==0: state=RUN, req_o=1 next cycle.
  - If target[1:0]!=0: state=FAULT, req_o=0, adef_o=1, adef_addr_o=target, pc_o=target.
- FAULT:
  - req_o=0 and fire_o=0; pc_o holds.
  - branch_flag_i is ignored.
  - Only flush exits: aligned target → RUN with adef_o=0; misaligned target → stays FAULT with adef_addr_o updated.
- fire_o is forced 0 in any cycle where flush or branch_flag_i is high, so no advance coincides with a redirect.
- Arithmetic: pc_o+FETCH_STEP is modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- Stall longer than one cycle: pc_o and req_o are held stable; memory sees the same request repeated.
- mem_ready_i low: same hold behaviour as stall; no timeout.
- Simultaneous flush+branch: flush target is used; the branch is dropped, not queued.
- Latency: redirect-to-new-pc_o is 1 cycle; fire-to-incremented-pc_o is 1 cycle.

Test Plan:
- Reset release, mem_ready_i=1, stall=0 → cycle 0 req_o=0 pc_o=0x1C000000; then pc_o=0x1C000000, 0x1C000004, 0x1C000008 with req_o=1 and fire_o=1 each cycle.
- stall=1 for 3 cycles at pc_o=0x1C000010 → pc_o holds 0x1C000010 and fire_o=0 throughout; stall drop → next pc_o=0x1C000014.
- branch_flag_i=1, branch_target_i=0x1C000100 during stall=1 → next cycle pc_o=0x1C000100, req_o=1; after stall releases, sequence continues at 0x1C000104.
- flush=1 (target 0x1C008000) and branch_flag_i=1 (target 0x1C000200) in the same cycle → pc_o=0x1C008000, no later pc_o=0x1C000200.
- branch target 0x1C000102 → FAULT: adef_o=1, adef_addr_o=0x1C000102, req_o=0; a further branch is ignored; flush to 0x1C008000 → RUN, adef_o=0, pc_o=0x1C008000.
- Start from pc_o=0xFFFFFFFC with fire_o=1 → next pc_o=0x00000000; assert rst mid-stream → same-cycle (async) pc_o=0x1C000000, req_o=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Front-end PC generator.
// Produces the fetch address stream for instruction memory.
// The PC advances on accepted fetches and redirects on branch or flush.
// A misaligned redirect target parks the block in FAULT until a flush arrives.
module pc_sequencer #(
  parameter int unsigned                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]        RESET_PC   = 'h1C00_0000,
  parameter int unsigned                  FETCH_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_target_i,
  input  logic                  branch_flag_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  req_o,
  output logic                  fire_o,
  output logic                  adef_o,
  output logic [ADDR_WIDTH-1:0] adef_addr_o
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] adef_addr_q, adef_addr_d;
  logic [ADDR_WIDTH-1:0] tgt;
  logic                  tgt_mis;

  // Flush wins over branch; the losing branch is simply dropped.
  assign tgt     = flush ? flush_target_i : branch_target_i;
  assign tgt_mis = (tgt[1:0] != 2'b00);

  // The request is withdrawn in any cycle a redirect is being taken, so a
  // fetch never fires alongside a redirect.
  assign req_o       = (state_q == RUN) & ~flush & ~branch_flag_i;
  assign fire_o      = req_o & mem_ready_i & ~stall;
  assign pc_o        = pc_q;
  assign adef_o      = (state_q == FAULT);
  assign adef_addr_o = adef_addr_q;

  // Next-state, next-PC and fault-address selection.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    adef_addr_d = adef_addr_q;
    unique case (state_q)
      FAULT: begin
        // Only a flush can leave FAULT; branches are ignored here.
        if (flush) begin
          pc_d    = flush_target_i;
          state_d = tgt_mis ? FAULT : RUN;
          if (tgt_mis) adef_addr_d = flush_target_i;
        end
      end
      default: begin
        // BOOT and RUN share redirect handling; BOOT only differs in
        // having no request out, so it never advances.
        if (flush || branch_flag_i) begin
          pc_d    = tgt;
          state_d = tgt_mis ? FAULT : RUN;
          if (tgt_mis) adef_addr_d = tgt;
        end else begin
          if (fire_o) pc_d = pc_q + ADDR_WIDTH'(FETCH_STEP);
          state_d = RUN;
        end
      end
    endcase
  end

  // State and address registers; async reset returns to BOOT at RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      adef_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      adef_addr_q <= adef_addr_d;
    end
  end

endmodule
